mbm_seq_multiplier: RTL and testbench

- Iterative unsigned W x W shift-and-add multiplier. It drives the team's W-bit ripple adder slice with one partial product per cycle and accumulates the running sum.
- Produces the full 2W-bit product and a W-bit minimally biased, round-half-up truncated result.
- Sits directly upstream of the adder datapath. It sequences operands into the adder and consumes its sum and carry each cycle.
- Start/busy/done handshake toward the requesting controller.

---
 rtl/mbm_seq_multiplier.sv | 116 +++++++++++
 tb/tb_mbm_seq_multiplier.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mbm_seq_multiplier.sv
// Iterative unsigned W x W shift-and-add multiplier with start/busy/done handshake.
// Produces the full 2W-bit product and a round-half-up W-bit truncated result.
module mbm_seq_multiplier #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product,
   output logic [W-1:0]   product_rnd
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [2*W-1:0] HALF = (2*W)'(1) << (W-1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [2*W:0]   acc_q, acc_d;
   logic [CW-1:0]  count_q, count_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [2*W-1:0] product_q, product_d;
   logic [W-1:0]   rnd_q, rnd_d;

   // W-bit adder slice; its unused MSB input bit is tied 0 and carry-in is 0
   logic [W:0]     add_a, add_b, add_s;
   logic [2*W-1:0] rnd_sum;

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      count_d   = count_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      product_d = product_q;
      rnd_d     = rnd_q;
      rnd_sum   = '0;

      add_a = {1'b0, acc_q[2*W-1:W]};
      add_b = {1'b0, (mplier_q[0] ? mcand_q : {W{1'b0}})};
      add_s = add_a + add_b;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = a;
               mplier_d = b;
               acc_d    = '0;
               count_d  = '0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            // cout lands in the MSB; the shift drops the consumed multiplier bit
            acc_d    = {add_s, acc_q[W-1:0]} >> 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (count_q == CW'(W-1)) begin
               rnd_sum   = acc_d[2*W-1:0] + HALF;
               product_d = acc_d[2*W-1:0];
               rnd_d     = rnd_sum[2*W-1:W];
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
         rnd_q     <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
         rnd_q     <= rnd_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign product     = product_q;
   assign product_rnd = rnd_q;

endmodule

// File: tb/tb_mbm_seq_multiplier.sv
// Self-checking bench for mbm_seq_multiplier: directed cases, mid-run reset,
// exhaustive sweep and random pairs checked against an arithmetic reference.
module tb_mbm_seq_multiplier;

   localparam int W = 4;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic [W-1:0]   product_rnd;

   int          vectors     = 0;
   int          miscompares = 0;
   longint      cyc         = 0;
   longint      last_done_cyc = 0;
   bit          check_gap   = 0;
   logic [63:0] prev_p      = '0;
   logic [63:0] prev_r      = '0;

   mbm_seq_multiplier #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .product     (product),
      .product_rnd (product_rnd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_prod(input int x, input int y);
      return 64'(x * y);
   endfunction

   function automatic logic [63:0] ref_rnd(input int x, input int y);
      return 64'((x * y + (1 << (W-1))) / (1 << W));
   endfunction

   // Watch for a number of cycles; nothing may start and no done may appear.
   task automatic expect_quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({tag, "_busy"}, 64'(busy), 64'd0);
         chk({tag, "_done"}, 64'(done), 64'd0);
      end
   endtask

   // One complete operation starting from IDLE. poke re-asserts start with
   // different operands during RUN and during DONE.
   task automatic run_op(input int ta, input int tb, input bit poke);
      int  busy_cycles;
      int  waited;
      bit  seen;
      logic [63:0] ep, er;
      ep = ref_prod(ta, tb);
      er = ref_rnd(ta, tb);
      @(negedge clk);
      a = W'(ta); b = W'(tb); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      chk("hold_prod_in_run", 64'(product), prev_p);
      chk("hold_rnd_in_run", 64'(product_rnd), prev_r);
      busy_cycles = 0; seen = 0; waited = 0;
      while (!seen && waited < 20) begin
         if (busy) busy_cycles++;
         if (done) seen = 1;
         else begin
            if (poke) begin
               start = (waited == 1);
               a = W'(15); b = W'(15);
            end
            @(negedge clk);
            waited++;
         end
      end
      if (!seen) begin
         chk("done_timeout", 64'd0, 64'd1);
         return;
      end
      chk("busy_cycles", 64'(busy_cycles), 64'(W));
      chk("busy_in_done", 64'(busy), 64'd0);
      chk("product", 64'(product), ep);
      chk("product_rnd", 64'(product_rnd), er);
      if (check_gap) chk("done_spacing", 64'(cyc - last_done_cyc), 64'(W + 2));
      last_done_cyc = cyc;
      prev_p = ep;
      prev_r = er;
      if (poke) begin
         start = 1'b1; a = W'(15); b = W'(15);
         @(negedge clk);
         start = 1'b0;
         chk("post_done_pulse", 64'(done), 64'd0);
         chk("post_hold_prod", 64'(product), ep);
         expect_quiet("no_requeue", 8);
         chk("poke_hold_prod", 64'(product), ep);
         chk("poke_hold_rnd", 64'(product_rnd), er);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_prod", 64'(product), 64'd0);
      chk("rst_rnd", 64'(product_rnd), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Full-scale operands, then outputs must hold while idle
      run_op(15, 15, 0);
      expect_quiet("idle_after_15x15", 3);
      chk("hold_prod_idle", 64'(product), 64'd225);
      chk("hold_rnd_idle", 64'(product_rnd), 64'd14);

      // Rounding tie and just-below-tie; zero operands
      run_op(8, 1, 0);
      run_op(7, 1, 0);
      run_op(0, 13, 0);
      run_op(13, 0, 0);

      // Start pulses during RUN and DONE are ignored
      run_op(5, 6, 1);

      // Asynchronous reset in the second RUN cycle discards the operation
      @(negedge clk);
      a = W'(9); b = W'(11); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_prod", 64'(product), 64'd0);
      chk("mid_rst_rnd", 64'(product_rnd), 64'd0);
      prev_p = '0; prev_r = '0;
      @(negedge clk);
      rst_n = 1'b1;
      expect_quiet("after_rst", 8);
      run_op(9, 11, 0);

      // Exhaustive sweep with back-to-back starts
      check_gap = 0;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            run_op(i, j, 0);
            check_gap = 1;
         end
      end

      // Random pairs, still back-to-back
      for (int k = 0; k < 40; k++) begin
         run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
      end
      check_gap = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
